// File: rtl/ramcon_pkg.sv
// Shared types and sizes for the PSRAM controller.
// The state enum, bus widths and boot delay default live here.
package ramcon_pkg;

  localparam int ADR_W           = 23;
  localparam int DAT_W           = 16;
  localparam int BOOT_CYCLES_DEF = 8192;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_IDLE = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  // Active-low PSRAM byte lanes {ub_n, lb_n} from a Wishbone select {upper, lower}
  function automatic logic [1:0] byte_en_n(input logic [1:0] sel);
    return ~sel;
  endfunction

endpackage

// File: rtl/ramcon_boot_timer.sv
// Power-up hold counter: counts clocks while run_i is high and
// saturates at CYCLES-1, where expired_o rises.
module ramcon_boot_timer
  import ramcon_pkg::*;
#(
  parameter int CYCLES = BOOT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Advance while running, hold once the last count is reached
  always_comb begin
    cnt_d = cnt_q;
    if (run_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, restarted by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/ramcon.sv
// Wishbone slave to asynchronous PSRAM controller: boot hold, then a fixed
// six-clock access sequence (address phase, three waits, data phase, ack).
module ramcon
  import ramcon_pkg::*;
#(
  parameter int BOOT_CYCLES = BOOT_CYCLES_DEF
) (
  input  logic             clk2x_i,
  input  logic             reset_i,
  output logic             reset_o,
  output logic             ram_cre_o,
  output logic             ram_ce_on,
  output logic             ram_adv_on,
  output logic             ram_oe_on,
  output logic             ram_we_on,
  output logic             ram_ub_on,
  output logic             ram_lb_on,
  output logic [ADR_W-1:0] ram_adr_o,
  inout  wire  [DAT_W-1:0] ram_dq_io,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic [1:0]       wb_sel_i,
  input  logic [DAT_W-1:0] wb_dat_i,
  output logic [DAT_W-1:0] wb_dat_o,
  output logic             wb_ack_o
);

  state_e           state_q;
  state_e           state_d;
  logic             we_q;
  logic             we_d;
  logic [DAT_W-1:0] dat_q;
  logic [DAT_W-1:0] dat_d;
  logic             reset_q;
  logic             reset_d;

  logic             boot_done_s;
  logic             req_s;
  logic             ce_n_s;
  logic             adv_n_s;
  logic             oe_n_s;
  logic             we_n_s;
  logic [1:0]       be_n_s;
  logic             dq_oe_s;
  logic             ack_s;

  ramcon_boot_timer #(
    .CYCLES(BOOT_CYCLES)
  ) u_boot_timer (
    .clk_i    (clk2x_i),
    .rst_i    (reset_i),
    .run_i    (state_q == ST_BOOT),
    .expired_o(boot_done_s)
  );

  assign req_s = wb_cyc_i & wb_stb_i;

  // Sequencer: next state, latched direction and PSRAM strobes per phase
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    ce_n_s  = 1'b1;
    adv_n_s = 1'b1;
    oe_n_s  = 1'b1;
    we_n_s  = 1'b1;
    be_n_s  = 2'b11;
    dq_oe_s = 1'b0;
    ack_s   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (boot_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BOOT;
        end
      end
      ST_IDLE: begin
        if (req_s) begin
          // Address phase is issued in the request cycle itself
          ce_n_s  = 1'b0;
          adv_n_s = 1'b0;
          we_d    = wb_we_i;
          state_d = ST_T1;
          if (wb_we_i) begin
            we_n_s = 1'b0;
          end else begin
            be_n_s = byte_en_n(wb_sel_i);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_T1: begin
        ce_n_s  = 1'b0;
        state_d = ST_T2;
      end
      ST_T2: begin
        ce_n_s  = 1'b0;
        state_d = ST_T3;
      end
      ST_T3: begin
        ce_n_s  = 1'b0;
        state_d = ST_T4;
        if (we_q) begin
          be_n_s  = byte_en_n(wb_sel_i);
          dq_oe_s = 1'b1;
        end else begin
          be_n_s = 2'b11;
        end
      end
      ST_T4: begin
        ce_n_s  = 1'b0;
        state_d = ST_DONE;
        if (we_q) begin
          be_n_s  = byte_en_n(wb_sel_i);
          dq_oe_s = 1'b1;
        end else begin
          oe_n_s = 1'b0;
        end
      end
      ST_DONE: begin
        ack_s   = req_s;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Read data capture kept apart from the pad enable to avoid a bus loop
  always_comb begin
    if ((state_q == ST_T4) && !we_q) begin
      dat_d = ram_dq_io;
    end else begin
      dat_d = dat_q;
    end
  end

  // Downstream reset follows the boot phase
  always_comb begin
    if (state_d == ST_BOOT) begin
      reset_d = 1'b1;
    end else begin
      reset_d = 1'b0;
    end
  end

  // State, direction, read data and downstream reset registers
  always_ff @(posedge clk2x_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_BOOT;
      we_q    <= 1'b0;
      dat_q   <= '0;
      reset_q <= 1'b1;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      reset_q <= reset_d;
    end
  end

  assign reset_o    = reset_q;
  assign ram_cre_o  = 1'b0;
  assign ram_ce_on  = ce_n_s;
  assign ram_adv_on = adv_n_s;
  assign ram_oe_on  = oe_n_s;
  assign ram_we_on  = we_n_s;
  assign ram_ub_on  = be_n_s[1];
  assign ram_lb_on  = be_n_s[0];
  assign ram_adr_o  = wb_adr_i;
  assign ram_dq_io  = dq_oe_s ? wb_dat_i : {DAT_W{1'bz}};
  assign wb_dat_o   = dat_q;
  assign wb_ack_o   = ack_s;

endmodule

// File: tb/tb_ramcon.sv
// Bench for ramcon: per-cycle expectations from a transaction-index model,
// random Wishbone traffic plus directed boot, reset and byte-lane cases.
module tb_ramcon;

  localparam int BOOT = 8192;

  logic        clk      = 1'b0;
  logic        reset_i  = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i  = 1'b0;
  logic [22:0] wb_adr_i = 23'h0;
  logic [1:0]  wb_sel_i = 2'b00;
  logic [15:0] wb_dat_i = 16'h0001;
  logic [15:0] psram_val = 16'h0000;

  logic        reset_o, ram_cre_o, ram_ce_on, ram_adv_on, ram_oe_on, ram_we_on;
  logic        ram_ub_on, ram_lb_on, wb_ack_o;
  logic [22:0] ram_adr_o;
  logic [15:0] wb_dat_o;
  wire  [15:0] ram_dq_io;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: clocks since reset, index into the 6-cycle access
  int          m_clocks = 0;
  int          m_k      = -1;
  logic        m_we     = 1'b0;
  logic [15:0] m_rdata  = 16'h0000;

  int   e_k;
  int   e_mode;
  logic e_rst, e_ce, e_adv, e_oe, e_we, e_ub, e_lb, e_ack;

  logic        obs_ce[6], obs_adv[6], obs_oe[6], obs_we[6], obs_ub[6], obs_lb[6], obs_ack[6];
  logic [22:0] obs_adr[6];
  logic [15:0] obs_dq[6], obs_dat[6];

  ramcon dut (
    .clk2x_i   (clk),
    .reset_i   (reset_i),
    .reset_o   (reset_o),
    .ram_cre_o (ram_cre_o),
    .ram_ce_on (ram_ce_on),
    .ram_adv_on(ram_adv_on),
    .ram_oe_on (ram_oe_on),
    .ram_we_on (ram_we_on),
    .ram_ub_on (ram_ub_on),
    .ram_lb_on (ram_lb_on),
    .ram_adr_o (ram_adr_o),
    .ram_dq_io (ram_dq_io),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_sel_i  (wb_sel_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o)
  );

  // PSRAM device: drives the bus whenever its output enable is low
  assign ram_dq_io = (ram_oe_on == 1'b0) ? psram_val : 16'hzzzz;

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic released(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  // -2 booting/reset, -1 idle, 0..5 position inside an access
  function automatic int k_now();
    if (reset_i || (m_clocks < BOOT)) return -2;
    if (m_k >= 0) return m_k;
    if (wb_cyc_i && wb_stb_i) return 0;
    return -1;
  endfunction

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_clocks <= 0;
      m_k      <= -1;
      m_we     <= 1'b0;
      m_rdata  <= 16'h0000;
    end else begin
      if (k_now() == 0) m_we <= wb_we_i;
      if ((k_now() == 4) && !m_we) m_rdata <= psram_val;
      if ((k_now() >= 0) && (k_now() < 5)) m_k <= k_now() + 1;
      else m_k <= -1;
      if (m_clocks < BOOT) m_clocks <= m_clocks + 1;
    end
  end

  always_comb begin
    e_k    = k_now();
    e_rst  = (e_k == -2);
    e_ce   = 1'b1;
    e_adv  = 1'b1;
    e_oe   = 1'b1;
    e_we   = 1'b1;
    e_ub   = 1'b1;
    e_lb   = 1'b1;
    e_ack  = 1'b0;
    e_mode = 0;
    case (e_k)
      0: begin
        e_ce  = 1'b0;
        e_adv = 1'b0;
        if (wb_we_i) e_we = 1'b0;
        else begin
          e_ub = ~wb_sel_i[1];
          e_lb = ~wb_sel_i[0];
        end
      end
      1, 2: e_ce = 1'b0;
      3, 4: begin
        e_ce = 1'b0;
        if (m_we) begin
          e_ub   = ~wb_sel_i[1];
          e_lb   = ~wb_sel_i[0];
          e_mode = 1;
        end else if (e_k == 4) begin
          e_oe   = 1'b0;
          e_mode = 2;
        end
      end
      5: e_ack = wb_cyc_i && wb_stb_i;
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if ($time > 5) begin
      chk("reset_o", reset_o, e_rst);
      chk("cre", ram_cre_o, 1'b0);
      chk("ce", ram_ce_on, e_ce);
      chk("adv", ram_adv_on, e_adv);
      chk("oe", ram_oe_on, e_oe);
      chk("we", ram_we_on, e_we);
      chk("ub", ram_ub_on, e_ub);
      chk("lb", ram_lb_on, e_lb);
      chk("ack", wb_ack_o, e_ack);
      chk("adr", ram_adr_o, wb_adr_i);
      chk("dat_o", wb_dat_o, m_rdata);
      if (e_mode == 1) chk("dq_wr", ram_dq_io, wb_dat_i);
      else if (e_mode == 2) chk("dq_rd", ram_dq_io, psram_val);
      else chk("dq_rel", released(ram_dq_io), 1'b1);
    end
  end

  task automatic run_txn(input logic we, input logic [22:0] adr, input logic [1:0] sel,
                         input logic [15:0] dat, input logic [15:0] pv,
                         input int drop_k, input int rst_k);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat; psram_val = pv;
    for (int k = 0; k < 6; k++) begin
      if (k == drop_k) wb_stb_i = 1'b0;
      @(negedge clk);
      obs_ce[k] = ram_ce_on;  obs_adv[k] = ram_adv_on; obs_oe[k] = ram_oe_on;
      obs_we[k] = ram_we_on;  obs_ub[k]  = ram_ub_on;  obs_lb[k] = ram_lb_on;
      obs_ack[k] = wb_ack_o;  obs_adr[k] = ram_adr_o;  obs_dq[k] = ram_dq_io;
      obs_dat[k] = wb_dat_o;
      if (k == rst_k) begin
        #2 reset_i = 1'b1;
        #1;
        chk("rst_mid_reset_o", reset_o, 1'b1);
        chk("rst_mid_ce", ram_ce_on, 1'b1);
        chk("rst_mid_ack", wb_ack_o, 1'b0);
        chk("rst_mid_dat", wb_dat_o, 16'h0000);
        chk("rst_mid_dq", released(ram_dq_io), 1'b1);
        #2 reset_i = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1 reset_i = 1'b1;
    #29;
    @(posedge clk); #1 reset_i = 1'b0;

    // Requests during boot are ignored
    repeat (100) @(posedge clk);
    #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 23'h000777;
    repeat (20) begin
      @(negedge clk);
      chk("boot_req_ce", ram_ce_on, 1'b1);
      chk("boot_req_ack", wb_ack_o, 1'b0);
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

    repeat (7379) @(negedge clk);
    chk("boot_150us_reset_o", reset_o, 1'b1);
    chk("boot_150us_ce", ram_ce_on, 1'b1);
    chk("boot_150us_ack", wb_ack_o, 1'b0);
    repeat (9000) @(negedge clk);
    chk("boot_330us_reset_o", reset_o, 1'b0);
    @(posedge clk); #1;

    // Directed read, then back-to-back write
    run_txn(1'b0, 23'h012345, 2'b11, 16'h1357, 16'hD00D, -1, -1);
    chk("rd_adr0", obs_adr[0], 23'h012345);
    chk("rd_adv0", obs_adv[0], 1'b0);
    chk("rd_ub0", obs_ub[0], 1'b0);
    chk("rd_lb0", obs_lb[0], 1'b0);
    for (int i = 0; i < 5; i++) chk("rd_ce_low", obs_ce[i], 1'b0);
    chk("rd_oe3", obs_oe[3], 1'b1);
    chk("rd_oe4", obs_oe[4], 1'b0);
    chk("rd_ack5", obs_ack[5], 1'b1);
    chk("rd_ce5", obs_ce[5], 1'b1);
    chk("rd_dat5", obs_dat[5], 16'hD00D);

    run_txn(1'b1, 23'h012345, 2'b11, 16'h0BAD, 16'h0000, -1, -1);
    chk("wr_we0", obs_we[0], 1'b0);
    chk("wr_ub0", obs_ub[0], 1'b1);
    chk("wr_lb0", obs_lb[0], 1'b1);
    chk("wr_ub3", obs_ub[3], 1'b0);
    chk("wr_dq3", obs_dq[3], 16'h0BAD);
    chk("wr_dq4", obs_dq[4], 16'h0BAD);
    chk("wr_ack5", obs_ack[5], 1'b1);
    chk("wr_ce5", obs_ce[5], 1'b1);

    // Byte lanes
    run_txn(1'b1, 23'h000100, 2'b01, 16'h5A5A, 16'h0000, -1, -1);
    chk("wr01_ub3", obs_ub[3], 1'b1);
    chk("wr01_lb3", obs_lb[3], 1'b0);
    run_txn(1'b0, 23'h000101, 2'b10, 16'h0F0F, 16'h4321, -1, -1);
    chk("rd10_ub0", obs_ub[0], 1'b0);
    chk("rd10_lb0", obs_lb[0], 1'b1);
    chk("rd10_dat5", obs_dat[5], 16'h4321);

    // Strobe dropped in T2: sequence completes without ack
    idle(1);
    run_txn(1'b0, 23'h000200, 2'b11, 16'h0001, 16'hBEEF, 2, -1);
    chk("drop_ce4", obs_ce[4], 1'b0);
    chk("drop_ack5", obs_ack[5], 1'b0);
    chk("drop_dat5", obs_dat[5], 16'hBEEF);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      int gap, drop;
      gap  = $urandom_range(0, 2);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : -1;
      if (gap > 0) idle(gap);
      run_txn(1'($urandom_range(0, 1)), 23'($urandom), 2'($urandom_range(0, 3)),
              16'($urandom_range(1, 65535)), 16'($urandom), drop, -1);
    end

    // Reset pulse in T2 of a write, then a full boot again
    idle(2);
    run_txn(1'b1, 23'h0ABCDE, 2'b11, 16'h1234, 16'h0000, -1, 2);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (BOOT - 2) @(posedge clk);
    @(negedge clk);
    chk("reboot_last_boot_clk", reset_o, 1'b1);
    @(negedge clk);
    chk("reboot_released", reset_o, 1'b0);
    @(posedge clk); #1;
    run_txn(1'b0, 23'h7FFFFF, 2'b01, 16'h0002, 16'hCAFE, -1, -1);
    chk("reboot_rd_dat5", obs_dat[5], 16'hCAFE);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
